// File: rtl/rv32_branch_predictor_if.sv
// -----------------------------------------------------------------------------
// rv32_branch_predictor_if
// Bundles the fetch-side lookup, the execute-side resolution and the
// performance counter readout of the branch predictor.
//   master : pipeline side (drives lk_pc, up_*, flush_tbl; reads predictions,
//            redirect request and counters)
//   slave  : predictor side
// XLEN and CNT_W must match the parameters of the attached predictor.
// -----------------------------------------------------------------------------
interface rv32_branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             flush_tbl;
    // fetch lookup
    logic [XLEN-1:0]  lk_pc;
    logic             lk_hit;
    logic             lk_taken;
    logic [XLEN-1:0]  lk_target;
    // resolved control-flow update
    logic             up_valid;
    logic [XLEN-1:0]  up_pc;
    logic             up_is_br;
    logic             up_taken;
    logic [XLEN-1:0]  up_target;
    logic             up_pred_taken;
    logic [XLEN-1:0]  up_pred_target;
    // redirect request
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    // performance counters
    logic [CNT_W-1:0] cnt_lookups;
    logic [CNT_W-1:0] cnt_mispred;

    modport master (
        output flush_tbl, lk_pc,
               up_valid, up_pc, up_is_br, up_taken, up_target,
               up_pred_taken, up_pred_target,
        input  lk_hit, lk_taken, lk_target,
               mispredict, redirect_pc, cnt_lookups, cnt_mispred
    );

    modport slave (
        input  flush_tbl, lk_pc,
               up_valid, up_pc, up_is_br, up_taken, up_target,
               up_pred_taken, up_pred_target,
        output lk_hit, lk_taken, lk_target,
               mispredict, redirect_pc, cnt_lookups, cnt_mispred
    );
endinterface

// File: rtl/rv32_branch_predictor.sv
// -----------------------------------------------------------------------------
// rv32_branch_predictor
// Direct-mapped BTB with a per-entry saturating direction counter.
// Fetch lookup is zero-latency from the registered table; the resolved
// outcome from execute trains the table on the next rising edge, raises a
// combinational redirect on mispredict, and bumps saturating perf counters.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   bp    - rv32_branch_predictor_if.slave (lookup, update, redirect, counters)
// -----------------------------------------------------------------------------
module rv32_branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    rv32_branch_predictor_if.slave   bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    // Only the MSB set: weakly taken (works for CTR_BITS = 1 too).
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1'b1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);
    localparam logic [XLEN-1:0]     PC_STEP  = XLEN'(3'd4);

    // Saturating up/down step of a direction counter.
    function automatic logic [CTR_BITS-1:0] ctr_train(
        input logic [CTR_BITS-1:0] ctr,
        input logic                taken
    );
        logic [CTR_BITS-1:0] res;
        if (taken) begin
            res = (ctr == CTR_MAX) ? ctr : ctr + CTR_ONE;
        end else begin
            res = (ctr == {CTR_BITS{1'b0}}) ? ctr : ctr - CTR_ONE;
        end
        return res;
    endfunction

    // Saturating increment of a performance counter.
    function automatic logic [CNT_W-1:0] cnt_bump(
        input logic [CNT_W-1:0] cnt,
        input logic             en
    );
        logic [CNT_W-1:0] res;
        if (en && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Table storage
    logic                valid_r  [ENTRIES];
    logic [TAG_W-1:0]    tag_r    [ENTRIES];
    logic [XLEN-1:0]     target_r [ENTRIES];
    logic [CTR_BITS-1:0] ctr_r    [ENTRIES];

    logic [CNT_W-1:0]    cnt_lookups_r;
    logic [CNT_W-1:0]    cnt_mispred_r;

    logic [IDX_W-1:0]    lk_idx_s;
    logic [TAG_W-1:0]    lk_tag_s;
    logic                lk_hit_s;
    logic                lk_taken_s;
    logic [XLEN-1:0]     lk_target_s;

    logic [IDX_W-1:0]    up_idx_s;
    logic [TAG_W-1:0]    up_tag_s;
    logic                up_hit_s;
    logic                wr_en_s;
    logic [XLEN-1:0]     wr_target_s;
    logic [CTR_BITS-1:0] wr_ctr_s;
    logic                mispredict_s;

    assign lk_idx_s = bp.lk_pc[IDX_W+1:2];
    assign lk_tag_s = bp.lk_pc[XLEN-1:IDX_W+2];
    assign up_idx_s = bp.up_pc[IDX_W+1:2];
    assign up_tag_s = bp.up_pc[XLEN-1:IDX_W+2];

    // Fetch lookup: reads the registered table only, so a same-cycle update
    // to the same index is not visible until the following cycle.
    always_comb begin
        lk_hit_s    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        lk_taken_s  = lk_hit_s && ctr_r[lk_idx_s][CTR_BITS-1];
        if (lk_taken_s) begin
            lk_target_s = target_r[lk_idx_s];
        end else begin
            lk_target_s = bp.lk_pc + PC_STEP;
        end
    end

    // Redirect request from the resolved outcome versus what was predicted.
    always_comb begin
        mispredict_s = bp.up_valid &&
                       ((bp.up_pred_taken != bp.up_taken) ||
                        (bp.up_taken && (bp.up_pred_target != bp.up_target)));
    end

    // Next contents of the entry addressed by the resolved PC.
    // A flush in the same cycle suppresses any training or allocation.
    always_comb begin
        up_hit_s    = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
        wr_en_s     = 1'b0;
        wr_target_s = target_r[up_idx_s];
        wr_ctr_s    = ctr_r[up_idx_s];
        if (bp.up_valid && !bp.flush_tbl) begin
            if (up_hit_s) begin
                wr_en_s = 1'b1;
                if (bp.up_is_br) begin
                    wr_ctr_s = ctr_train(ctr_r[up_idx_s], bp.up_taken);
                end else begin
                    wr_ctr_s = CTR_MAX;
                end
                if (bp.up_taken) begin
                    wr_target_s = bp.up_target;
                end else begin
                    wr_target_s = target_r[up_idx_s];
                end
            end else if (bp.up_taken) begin
                // Allocate, evicting whatever aliased to this index.
                wr_en_s     = 1'b1;
                wr_target_s = bp.up_target;
                if (bp.up_is_br) begin
                    wr_ctr_s = CTR_WEAK;
                end else begin
                    wr_ctr_s = CTR_MAX;
                end
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table update: async reset, flush of valid bits, single-entry write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {XLEN{1'b0}};
                ctr_r[i]    <= {CTR_BITS{1'b0}};
            end
        end else if (bp.flush_tbl) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (wr_en_s) begin
            valid_r[up_idx_s]  <= 1'b1;
            tag_r[up_idx_s]    <= up_tag_s;
            target_r[up_idx_s] <= wr_target_s;
            ctr_r[up_idx_s]    <= wr_ctr_s;
        end
    end

    // Saturating performance counters; unaffected by table flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_lookups_r <= {CNT_W{1'b0}};
            cnt_mispred_r <= {CNT_W{1'b0}};
        end else begin
            cnt_lookups_r <= cnt_bump(cnt_lookups_r, bp.up_valid);
            cnt_mispred_r <= cnt_bump(cnt_mispred_r, mispredict_s);
        end
    end

    assign bp.lk_hit      = lk_hit_s;
    assign bp.lk_taken    = lk_taken_s;
    assign bp.lk_target   = lk_target_s;
    assign bp.mispredict  = mispredict_s;
    assign bp.redirect_pc = bp.up_taken ? bp.up_target : (bp.up_pc + PC_STEP);
    assign bp.cnt_lookups = cnt_lookups_r;
    assign bp.cnt_mispred = cnt_mispred_r;

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_rv32_branch_predictor
// Directed vector table, reset/saturation sequences and randomized traffic
// checked against a behavioural model of the predictor.
// -----------------------------------------------------------------------------
module tb_rv32_branch_predictor;
    localparam int XLEN     = 32;
    localparam int ENTRIES  = 16;
    localparam int CTR_BITS = 2;
    localparam int CNT_W    = 4;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;
    localparam int CTR_TOP  = (1 << CTR_BITS) - 1;
    localparam int CTR_HALF = 1 << (CTR_BITS - 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32_branch_predictor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bp ();

    rv32_branch_predictor #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    bit          m_valid [ENTRIES];
    logic [29:0] m_line  [ENTRIES];   // word address of the owning PC
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_lk_cnt;
    int          m_mp_cnt;

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = 30'd0;
            m_tgt[i]   = 32'd0;
            m_ctr[i]   = 0;
        end
        m_lk_cnt = 0;
        m_mp_cnt = 0;
    endfunction

    function automatic int m_slot(input logic [31:0] pc);
        return int'(pc[31:2]) % ENTRIES;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit hit,
                                     output bit taken, output logic [31:0] tgt);
        int i;
        i     = m_slot(pc);
        hit   = m_valid[i] && (m_line[i] == pc[31:2]);
        taken = hit && (m_ctr[i] >= CTR_HALF);
        tgt   = taken ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        return bp.up_valid && ((bp.up_pred_taken != bp.up_taken) ||
               (bp.up_taken && (bp.up_pred_target != bp.up_target)));
    endfunction

    // Applies one clock edge worth of state change using the current inputs.
    function automatic void m_update();
        bit hit, tk;
        logic [31:0] tg;
        int i;
        if (bp.up_valid && m_lk_cnt < CNT_SAT) m_lk_cnt++;
        if (m_mispredict() && m_mp_cnt < CNT_SAT) m_mp_cnt++;
        if (bp.flush_tbl) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (bp.up_valid) begin
            m_lookup(bp.up_pc, hit, tk, tg);
            i = m_slot(bp.up_pc);
            if (hit) begin
                if (!bp.up_is_br)      m_ctr[i] = CTR_TOP;
                else if (bp.up_taken)  m_ctr[i] = (m_ctr[i] + 1 > CTR_TOP) ? CTR_TOP : m_ctr[i] + 1;
                else                   m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                if (bp.up_taken) m_tgt[i] = bp.up_target;
            end else if (bp.up_taken) begin
                m_valid[i] = 1'b1;
                m_line[i]  = bp.up_pc[31:2];
                m_tgt[i]   = bp.up_target;
                m_ctr[i]   = bp.up_is_br ? CTR_HALF : CTR_TOP;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        bit hit, tk;
        logic [31:0] tg;
        m_lookup(bp.lk_pc, hit, tk, tg);
        check({tag, ".lk_hit"},      32'(bp.lk_hit), 32'(hit));
        check({tag, ".lk_taken"},    32'(bp.lk_taken), 32'(tk));
        check({tag, ".lk_target"},   bp.lk_target, tg);
        check({tag, ".mispredict"},  32'(bp.mispredict), 32'(m_mispredict()));
        check({tag, ".redirect_pc"}, bp.redirect_pc,
              bp.up_taken ? bp.up_target : bp.up_pc + 32'd4);
        check({tag, ".cnt_lookups"}, 32'(bp.cnt_lookups), 32'(m_lk_cnt));
        check({tag, ".cnt_mispred"}, 32'(bp.cnt_mispred), 32'(m_mp_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] lk_pc;
        bit          uv;
        logic [31:0] upc;
        bit          is_br;
        bit          tk;
        logic [31:0] tgt;
        bit          ptk;
        logic [31:0] ptgt;
        bit          fl;
        bit          e_hit;
        bit          e_tk;
        logic [31:0] e_tgt;
        bit          e_mis;
        logic [31:0] e_redir;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic [31:0] lk_pc, input bit uv, input logic [31:0] upc,
        input bit is_br, input bit tk, input logic [31:0] tgt, input bit ptk,
        input logic [31:0] ptgt, input bit fl, input bit e_hit, input bit e_tk,
        input logic [31:0] e_tgt, input bit e_mis, input logic [31:0] e_redir);
        vec_t v;
        v.lk_pc = lk_pc; v.uv = uv; v.upc = upc; v.is_br = is_br; v.tk = tk;
        v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt; v.fl = fl; v.e_hit = e_hit;
        v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_mis = e_mis; v.e_redir = e_redir;
        return v;
    endfunction

    task automatic drive(input logic [31:0] lk_pc, input bit uv, input logic [31:0] upc,
                         input bit is_br, input bit tk, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt, input bit fl);
        bp.lk_pc = lk_pc;  bp.up_valid = uv;  bp.up_pc = upc;  bp.up_is_br = is_br;
        bp.up_taken = tk;  bp.up_target = tgt;  bp.up_pred_taken = ptk;
        bp.up_pred_target = ptgt;  bp.flush_tbl = fl;
    endtask

    initial begin
        //        lk_pc        uv upc          br tk tgt        ptk ptgt       fl  hit tk e_tgt      mis redir
        tbl[0]  = mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h104, 0, 32'h4);
        tbl[1]  = mk(32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h104, 0,  0, 0, 32'h104, 1, 32'h80);
        tbl[2]  = mk(32'h100, 1, 32'h100, 1, 0, 32'h80,  1, 32'h80,  0,  1, 1, 32'h80,  1, 32'h104);
        tbl[3]  = mk(32'h100, 1, 32'h100, 1, 0, 32'h80,  0, 32'h104, 0,  1, 0, 32'h104, 0, 32'h104);
        tbl[4]  = mk(32'h100, 1, 32'h100, 1, 0, 32'h80,  0, 32'h104, 0,  1, 0, 32'h104, 0, 32'h104);
        tbl[5]  = mk(32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h104, 0,  1, 0, 32'h104, 1, 32'h80);
        tbl[6]  = mk(32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h104, 0,  1, 0, 32'h104, 1, 32'h80);
        tbl[7]  = mk(32'h100, 1, 32'h100, 1, 1, 32'h80,  1, 32'h80,  0,  1, 1, 32'h80,  0, 32'h80);
        tbl[8]  = mk(32'h100, 1, 32'h100, 1, 1, 32'h80,  1, 32'h80,  0,  1, 1, 32'h80,  0, 32'h80);
        tbl[9]  = mk(32'h100, 1, 32'h100, 1, 0, 32'h80,  1, 32'h80,  0,  1, 1, 32'h80,  1, 32'h104);
        tbl[10] = mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0,  1, 1, 32'h80,  0, 32'h4);
        tbl[11] = mk(32'h140, 1, 32'h140, 1, 1, 32'h300, 0, 32'h144, 0,  0, 0, 32'h144, 1, 32'h300);
        tbl[12] = mk(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h104, 0, 32'h4);
        tbl[13] = mk(32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0,  1, 1, 32'h300, 0, 32'h4);
        tbl[14] = mk(32'h200, 1, 32'h200, 0, 1, 32'h400, 0, 32'h204, 0,  0, 0, 32'h204, 1, 32'h400);
        tbl[15] = mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0,  1, 1, 32'h400, 0, 32'h4);
        tbl[16] = mk(32'h200, 1, 32'h208, 1, 1, 32'h500, 0, 32'h20c, 1,  1, 1, 32'h400, 1, 32'h500);
        tbl[17] = mk(32'h208, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h20c, 0, 32'h4);
        tbl[18] = mk(32'h200, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h204, 0, 32'h4);
        tbl[19] = mk(32'h10,  1, 32'h10,  1, 1, 32'h50,  0, 32'h14,  0,  0, 0, 32'h14,  1, 32'h50);
        tbl[20] = mk(32'h10,  1, 32'h10,  1, 0, 32'h50,  1, 32'h50,  0,  1, 1, 32'h50,  1, 32'h14);
        tbl[21] = mk(32'h10,  1, 32'h10,  0, 1, 32'h60,  0, 32'h14,  0,  1, 0, 32'h14,  1, 32'h60);
        tbl[22] = mk(32'h10,  1, 32'h10,  1, 0, 32'h60,  1, 32'h60,  0,  1, 1, 32'h60,  1, 32'h14);
        tbl[23] = mk(32'h10,  0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0,  1, 1, 32'h60,  0, 32'h4);
        tbl[24] = mk(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 0, 32'h1234, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);

        // ---- reset ----
        rst = 1'b0;
        drive(32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.lk_hit",      32'(bp.lk_hit), 32'd0);
        check("reset.lk_taken",    32'(bp.lk_taken), 32'd0);
        check("reset.lk_target",   bp.lk_target, 32'h104);
        check("reset.cnt_lookups", 32'(bp.cnt_lookups), 32'd0);
        check("reset.cnt_mispred", 32'(bp.cnt_mispred), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ---- directed table ----
        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].lk_pc, tbl[k].uv, tbl[k].upc, tbl[k].is_br, tbl[k].tk,
                  tbl[k].tgt, tbl[k].ptk, tbl[k].ptgt, tbl[k].fl);
            @(negedge clk);
            check($sformatf("vec%0d.lk_hit", k),      32'(bp.lk_hit), 32'(tbl[k].e_hit));
            check($sformatf("vec%0d.lk_taken", k),    32'(bp.lk_taken), 32'(tbl[k].e_tk));
            check($sformatf("vec%0d.lk_target", k),   bp.lk_target, tbl[k].e_tgt);
            check($sformatf("vec%0d.mispredict", k),  32'(bp.mispredict), 32'(tbl[k].e_mis));
            check($sformatf("vec%0d.redirect_pc", k), bp.redirect_pc, tbl[k].e_redir);
            check($sformatf("vec%0d.cnt_lookups", k), 32'(bp.cnt_lookups), 32'(m_lk_cnt));
            check($sformatf("vec%0d.cnt_mispred", k), 32'(bp.cnt_mispred), 32'(m_mp_cnt));
            tick();
        end

        // ---- asynchronous reset mid-update ----
        drive(32'h10, 1, 32'h300, 1, 1, 32'h700, 0, 32'h304, 0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst.lk_hit",      32'(bp.lk_hit), 32'd0);
        check("async_rst.lk_taken",    32'(bp.lk_taken), 32'd0);
        check("async_rst.lk_target",   bp.lk_target, 32'h14);
        check("async_rst.mispredict",  32'(bp.mispredict), 32'd1);
        check("async_rst.redirect_pc", bp.redirect_pc, 32'h700);
        check("async_rst.cnt_lookups", 32'(bp.cnt_lookups), 32'd0);
        check("async_rst.cnt_mispred", 32'(bp.cnt_mispred), 32'd0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(32'h300, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
        #1;
        check("async_rst.no_alloc", 32'(bp.lk_hit), 32'd0);
        tick();

        // ---- perf counter saturation: 20 mispredicting updates ----
        for (int k = 0; k < 20; k++) begin
            bit tk;
            tk = 1'($urandom_range(0, 1));
            drive({$urandom_range(0, 3), 4'h0, 4'($urandom_range(0, 15)), 2'b00} & 32'hFFFF_FFFC,
                  1, 32'($urandom_range(0, 255)) << 2, 1, tk, $urandom & 32'hFFFF_FFFC,
                  ~tk, $urandom & 32'hFFFF_FFFC, 0);
            @(negedge clk);
            check_model($sformatf("sat%0d", k));
            tick();
        end
        drive(32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
        #1;
        check("sat.cnt_mispred", 32'(bp.cnt_mispred), 32'(CNT_SAT));
        check("sat.cnt_lookups", 32'(bp.cnt_lookups), 32'(CNT_SAT));

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 400; k++) begin
            logic [31:0] upc, lpc, tgt, ptgt;
            bit is_br, tk, ptk, mh, mt;
            logic [31:0] mtg;
            upc   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
            lpc   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 40) == 0) upc = 32'hFFFFFFFC;
            is_br = ($urandom_range(0, 3) != 0);
            tk    = is_br ? 1'($urandom_range(0, 1)) : 1'b1;
            tgt   = 32'($urandom_range(0, 63)) << 2;
            m_lookup(upc, mh, mt, mtg);
            if ($urandom_range(0, 1) == 1) begin
                ptk = mt; ptgt = mtg;
            end else begin
                ptk = 1'($urandom_range(0, 1)); ptgt = 32'($urandom_range(0, 63)) << 2;
            end
            drive(lpc, 1'($urandom_range(0, 3) != 0), upc, is_br, tk, tgt, ptk, ptgt,
                  $urandom_range(0, 30) == 0);
            @(negedge clk);
            check_model($sformatf("rnd%0d", k));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv32_branch_predictor.md
Name: rv32_branch_predictor

Overview:
Parametrised dynamic branch predictor (BTB + saturating-counter BHT) for the rv32 pipeline; it supersedes static br_expect/br_success resolution. Fetch looks up the current PC combinationally for predicted next-PC. The execute/access stage returns the resolved outcome; the block updates its tables, flags mispredicts with a redirect PC, and keeps saturating performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB/BHT entries; power of two, 2..256
CTR_BITS, 2, saturating counter width, 1..4
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
flush_tbl  in  1  synchronous invalidate of all valid bits
lk_pc  in  XLEN  fetch PC to look up
lk_hit  out  1  tag match on valid entry
lk_taken  out  1  prediction: hit and counter MSB = 1
lk_target  out  XLEN  predicted next PC: entry target if lk_taken, else lk_pc+4
up_valid  in  1  resolved control-flow instruction this cycle
up_pc  in  XLEN  PC of resolved instruction
up_is_br  in  1  1 = conditional branch, 0 = jal/jalr
up_taken  in  1  actual outcome (forced 1 for jumps)
up_target  in  XLEN  actual taken target
up_pred_taken  in  1  lk_taken carried down pipeline with instruction
up_pred_target  in  XLEN  lk_target carried down pipeline
mispredict  out  1  combinational redirect request
redirect_pc  out  XLEN  up_taken ? up_target : up_pc+4
cnt_lookups  out  CNT_W  resolved updates seen
cnt_mispred  out  CNT_W  mispredicts seen

Behaviour:
- IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. pc[1:0] ignored.
- Entry: valid, tag, target (XLEN), counter (CTR_BITS).
- Lookup purely combinational from registered table; zero latency. Miss -> lk_hit=0, lk_taken=0, lk_target=lk_pc+4.
- pc+4 arithmetic modulo 2^XLEN (wraps 0xFFFFFFFC -> 0x00000000).
- mispredict = up_valid & ((up_pred_taken != up_taken) | (up_taken & up_pred_target != up_target)). Combinational; 0 when up_valid=0.
- Update on rising edge when up_valid=1:
  - Hit: counter +1 if up_taken, -1 if not; saturate at 0 and 2^CTR_BITS-1. If up_taken, target <= up_target.
  - Miss & up_taken: allocate (overwrite index): valid=1, tag, target=up_target, counter = 2^(CTR_BITS-1) (weakly taken); jumps (up_is_br=0) allocate at max counter.
  - Miss & not taken: no table change.
  - Jump hit: counter forced to max.
- Read-before-write: lookup and update to same index in one cycle -> lookup sees old contents; new contents visible next cycle.
- flush_tbl: clears all valid bits next edge; counters/targets retained but unused. flush_tbl and up_valid together: flush wins, no allocation. Perf counters unaffected by flush_tbl.
- cnt_lookups +1 per up_valid cycle; cnt_mispred +1 per mispredict cycle; both saturate at 2^CNT_W-1 (no wrap).
- Reset (rst=0, asynchronous): all valid=0, counters=0, targets=0, tags=0, perf counters=0. Combinational outputs follow: lk_hit=0, lk_taken=0, lk_target=lk_pc+4, mispredict reflects inputs (0 if up_valid=0). Reset asserted mid-update aborts the write; no partial entry.
- No internal FSM beyond the table; pipeline stall handling is the caller's job (hold up_valid low during stall bubbles).

Test Plan:
- Reset, lk_pc=0x100 -> lk_hit=0, lk_taken=0, lk_target=0x104; cnt_* = 0.
- up_valid, up_pc=0x100, up_is_br=1, up_taken=1, up_target=0x80, up_pred_taken=0 -> mispredict=1, redirect_pc=0x80; next cycle lk_pc=0x100 -> lk_hit=1, lk_taken=1, lk_target=0x80; cnt_mispred=1.
- Same branch resolved not-taken twice from weakly taken (2) -> counter 1 then 0; lk_taken=0 after first; third not-taken stays 0; four taken updates saturate at 3.
- Aliasing: allocate 0x100 then taken update 0x100+4*ENTRIES (0x140 at 16) -> entry retagged; lookup 0x100 misses, 0x140 hits.
- Same-cycle lookup/update on index of 0x200 (initially empty) -> lk_hit=0 that cycle, 1 next cycle; flush_tbl with concurrent taken update -> lookup misses afterwards.
- CNT_W=4: 20 mispredicting updates -> cnt_mispred holds 15; pulse rst low mid-run -> all outputs return to reset values immediately, without waiting for a clock edge.
